// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the dmem load/store port.
//   - access size encodings (byte / half / word; 2'b11 is illegal)
//   - FSM state enum of dmem_port
//   - default word-address width of the attached data memory
//   - req_legal(): alignment / size legality check on a request
package mem_pkg;

  localparam int DEF_ADDR_W = 10;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // A request is legal when its size is known and its byte offset is
  // naturally aligned for that size.
  function automatic logic req_legal(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (size)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = ~off[0];
      SIZE_W:  ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_port_if.sv
// dmem_port_if: bundles the request, response and memory-side signals of
// dmem_port.
//   slave  : the dmem_port view (accepts requests, drives responses and memory)
//   master : the datapath + memory view (drives requests, consumes responses,
//            returns mem_rd)
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. Once valid is raised the sender holds valid and all payload
// signals stable until that edge; ready may be raised or lowered freely and
// never depends combinationally on valid.
// dbg_state mirrors the FSM state register for checkers.
interface dmem_port_if #(parameter int ADDR_W = mem_pkg::DEF_ADDR_W);
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;

  state_t            dbg_state;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_we, mem_addr, mem_wd, dbg_state
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_we, mem_addr, mem_wd, dbg_state
  );

endinterface

// File: rtl/mem_lane.sv
// mem_lane: combinational byte-lane helper for dmem_port.
//   off     : byte offset within the word (little-endian lanes)
//   size    : access size (SIZE_B / SIZE_H / SIZE_W)
//   uns     : zero-extend sub-word loads when 1, sign-extend when 0
//   rd      : word read from memory
//   wdata   : store data (low 8/16 bits used for byte/half)
//   ld_data : extracted and extended load value
//   merged  : rd with the addressed lane(s) replaced by wdata
module mem_lane
  import mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] rd,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;
  logic [31:0] ins;

  always_comb begin
    // Halfwords only arrive with off[0]==0, so one shift serves both sizes.
    sh      = {off, 3'b000};
    shifted = rd >> sh;
    ld_data = rd;
    mask    = 32'hFFFF_FFFF;
    ins     = wdata;
    case (size)
      SIZE_B: begin
        ld_data = {{24{~uns & shifted[7]}}, shifted[7:0]};
        mask    = 32'h0000_00FF << sh;
        ins     = {24'h0, wdata[7:0]} << sh;
      end
      SIZE_H: begin
        ld_data = {{16{~uns & shifted[15]}}, shifted[15:0]};
        mask    = 32'h0000_FFFF << sh;
        ins     = {16'h0, wdata[15:0]} << sh;
      end
      default: begin
        ld_data = rd;
        mask    = 32'hFFFF_FFFF;
        ins     = wdata;
      end
    endcase
    merged = (rd & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/dmem_port.sv
// dmem_port: load/store initiator in front of a word-wide data memory with a
// combinational read port.
//   clock, reset_n : clock and synchronous active-low reset
//   bus (slave)    : request channel (req_*), response channel (rsp_*),
//                    memory port (mem_we/mem_addr/mem_wd out, mem_rd in),
//                    dbg_state (current FSM state)
// Loads and word stores take one ACCESS cycle; byte/half stores read the word
// in ACCESS and write the merged word back in WRITE. Misaligned or illegal
// requests go straight to RESP with rsp_err set and never touch memory.
module dmem_port
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic        clock,
  input  logic        reset_n,
  dmem_port_if.slave  bus
);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_ready;
  logic              we_raw;
  logic [31:0]       wd;
  logic [31:0]       ld_data;
  logic [31:0]       merged;

  mem_lane u_lane (
    .off     (addr_q[1:0]),
    .size    (size_q),
    .uns     (uns_q),
    .rd      (bus.mem_rd),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .merged  (merged)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    merge_d   = merge_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    we_raw    = 1'b0;
    wd        = 32'h0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          rdata_d = 32'h0;
          if (req_legal(bus.req_size, bus.req_addr[1:0])) begin
            we_d    = bus.req_we;
            size_d  = bus.req_size;
            uns_d   = bus.req_unsigned;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            err_d   = 1'b0;
            state_d = ST_ACCESS;
          end else begin
            // Captured request left alone so mem_addr does not move.
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        if (!we_q) begin
          rdata_d = ld_data;
          state_d = ST_RESP;
        end else if (size_q == SIZE_W) begin
          we_raw  = 1'b1;
          wd      = wdata_q;
          state_d = ST_RESP;
        end else begin
          merge_d = merged;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        we_raw  = 1'b1;
        wd      = merge_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rdata_d = 32'h0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  // Gating with reset_n keeps a reset during ACCESS/WRITE from writing memory.
  assign bus.mem_we    = we_raw & reset_n;
  assign bus.mem_addr  = addr_q[ADDR_W+1:2];
  assign bus.mem_wd    = wd;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_dmem_port.sv
module tb_dmem_port;
  import mem_pkg::*;

  localparam int AW = 10;

  logic clock;
  logic reset_n;

  dmem_port_if #(.ADDR_W(AW)) bus ();

  dmem_port #(.ADDR_W(AW)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- memory model ----------------
  logic [31:0] mem_model [0:1023] = '{default: 32'h0};
  assign bus.mem_rd = mem_model[bus.mem_addr];
  always @(posedge clock) begin
    if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wd;
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];  // {rsp_err, rsp_rdata}
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation at every response handshake.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clock);
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {bus.rsp_err, bus.rsp_rdata}, 33'h1_DEAD_0000);
        end else begin
          e = exp_q.pop_front();
          chk("rsp", {bus.rsp_err, bus.rsp_rdata}, e);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one request and checks timing: response latency, the cycle of the
  // memory write (0 = none expected), its data and address. With hold > 0,
  // rsp_ready stays low for hold cycles while a competing request is offered.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input int exp_lat, input int exp_we_cyc,
                        input logic [31:0] exp_wd, input int hold);
    bit got_ready;
    bit seen;
    exp_q.push_back({exp_err, exp_rdata});
    bus.rsp_ready    = (hold == 0);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    got_ready = 1'b0;
    for (int i = 0; i < 50 && !got_ready; i++) begin
      @(negedge clock);
      if (bus.req_ready) got_ready = 1'b1;
    end
    if (!got_ready) chk("req_ready_timeout", 33'h0, 33'h1);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clock);
      if (bus.mem_we) begin
        chk("we_cycle", 33'(c), 33'(exp_we_cyc));
        chk("mem_wd", {1'b0, bus.mem_wd}, {1'b0, exp_wd});
        chk("mem_addr", 33'(bus.mem_addr), 33'(addr[11:2]));
      end else if (c == exp_we_cyc) begin
        chk("we_missing", 33'h0, 33'h1);
      end
      if (bus.rsp_valid) begin
        seen = 1'b1;
        chk("latency", 33'(c), 33'(exp_lat));
      end
    end
    if (!seen) chk("rsp_timeout", 33'h0, 33'h1);
    if (seen && hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clock);
        #1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SIZE_W;
        bus.req_addr  = 12'h020;
        bus.req_wdata = 32'hFFFF_FFFF;
        @(negedge clock);
        chk("bp_valid", {32'h0, bus.rsp_valid}, 33'h1);
        chk("bp_data", {bus.rsp_err, bus.rsp_rdata}, {exp_err, exp_rdata});
        chk("bp_req_ready", {32'h0, bus.req_ready}, 33'h0);
      end
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
    end
    if (seen) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {32'h0, bus.req_ready}, 33'h1);
    chk({tag, "_rsp_valid"}, {32'h0, bus.rsp_valid}, 33'h0);
    chk({tag, "_rsp"}, {bus.rsp_err, bus.rsp_rdata}, 33'h0);
    chk({tag, "_mem_we"}, {32'h0, bus.mem_we}, 33'h0);
    chk({tag, "_mem_addr"}, 33'(bus.mem_addr), 33'h0);
    chk({tag, "_mem_wd"}, {1'b0, bus.mem_wd}, 33'h0);
    chk({tag, "_state"}, 33'(bus.dbg_state), 33'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n          = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = SIZE_B;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 12'h0;
    bus.req_wdata    = 32'h0;
    bus.rsp_ready    = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    @(posedge clock);
    #1 reset_n = 1'b1;

    //       we    size    uns   addr     wdata          err   rdata          lat we_cyc wd            hold
    do_req(1'b1, SIZE_W, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 32'h00000000, 2, 1, 32'hDEADBEEF, 0);  // sw
    do_req(1'b0, SIZE_W, 1'b0, 12'h010, 32'h0,        1'b0, 32'hDEADBEEF, 2, 0, 32'h0,        0);  // lw
    do_req(1'b1, SIZE_B, 1'b0, 12'h011, 32'h000000A5, 1'b0, 32'h00000000, 3, 2, 32'hDEADA5EF, 0);  // sb
    do_req(1'b0, SIZE_B, 1'b0, 12'h011, 32'h0,        1'b0, 32'hFFFFFFA5, 2, 0, 32'h0,        0);  // lb
    do_req(1'b0, SIZE_B, 1'b1, 12'h011, 32'h0,        1'b0, 32'h000000A5, 2, 0, 32'h0,        0);  // lbu
    do_req(1'b1, SIZE_H, 1'b0, 12'h012, 32'h00001234, 1'b0, 32'h00000000, 3, 2, 32'h1234A5EF, 0);  // sh
    chk("word_after_sh", {1'b0, mem_model[4]}, {1'b0, 32'h1234A5EF});
    do_req(1'b0, SIZE_H, 1'b0, 12'h012, 32'h0,        1'b0, 32'h00001234, 2, 0, 32'h0,        0);  // lh hi
    do_req(1'b0, SIZE_H, 1'b0, 12'h010, 32'h0,        1'b0, 32'hFFFFA5EF, 2, 0, 32'h0,        0);  // lh lo
    do_req(1'b0, SIZE_H, 1'b1, 12'h010, 32'h0,        1'b0, 32'h0000A5EF, 2, 0, 32'h0,        0);  // lhu lo

    // Errors: never write, rdata 0, mem_addr stays on the last legal word (4).
    do_req(1'b0, SIZE_W, 1'b0, 12'h013, 32'h0,        1'b1, 32'h00000000, 1, 0, 32'h0,        0);  // lw misaligned
    do_req(1'b1, SIZE_H, 1'b0, 12'h011, 32'h0000BEEF, 1'b1, 32'h00000000, 1, 0, 32'h0,        0);  // sh misaligned
    do_req(1'b1, 2'b11,  1'b0, 12'h044, 32'hCAFEF00D, 1'b1, 32'h00000000, 1, 0, 32'h0,        0);  // illegal size
    chk("err_mem_addr", 33'(bus.mem_addr), 33'h4);
    chk("err_word4", {1'b0, mem_model[4]}, {1'b0, 32'h1234A5EF});
    chk("err_word17", {1'b0, mem_model[17]}, 33'h0);

    // Backpressure on a load with a competing store offered meanwhile.
    do_req(1'b0, SIZE_W, 1'b0, 12'h010, 32'h0,        1'b0, 32'h1234A5EF, 2, 0, 32'h0,        5);
    @(negedge clock);
    chk("bp_idle_after", 33'(bus.dbg_state), 33'(ST_IDLE));
    chk("bp_not_written", {1'b0, mem_model[8]}, 33'h0);

    // Reset during the WRITE cycle of sb 0x010.
    bus.req_we    = 1'b1;
    bus.req_size  = SIZE_B;
    bus.req_addr  = 12'h010;
    bus.req_wdata = 32'h00000077;
    bus.req_valid = 1'b1;
    @(posedge clock);           // accepted (T)
    #1 bus.req_valid = 1'b0;
    @(posedge clock);           // ACCESS -> WRITE
    #1 reset_n = 1'b0;
    @(negedge clock);
    chk("rst_write_state", 33'(bus.dbg_state), 33'(ST_WRITE));
    chk("rst_write_we", {32'h0, bus.mem_we}, 33'h0);
    @(negedge clock);
    check_reset_outputs("rst_mid");
    chk("rst_word4", {1'b0, mem_model[4]}, {1'b0, 32'h1234A5EF});
    @(posedge clock);
    #1 reset_n = 1'b1;

    do_req(1'b0, SIZE_B, 1'b1, 12'h010, 32'h0,        1'b0, 32'h000000EF, 2, 0, 32'h0,        0);  // lbu after reset

    repeat (3) @(negedge clock);
    chk("queue_empty", 33'(exp_q.size()), 33'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
